// File: rtl/t9990_clock_pkg.sv
// ---------------------------------------------------------------------------
// t9990_clock_pkg
// Shared types and constants for the tiny9990 dot-clock enable generator.
//   state_t       : SYNCING while hunting for the memory slot phase, RUN after.
//   DEF_*         : default build parameters of t9990_clock_gen.
//   SRC_*         : master clock-enable source indices (21.48 / 14.32 / 25.17 MHz).
//   sel_width()   : width of a source index field, never narrower than 1 bit.
// ---------------------------------------------------------------------------
package t9990_clock_pkg;

  typedef enum logic [0:0] {
    STATE_SYNCING = 1'b0,
    STATE_RUN     = 1'b1
  } state_t;

  localparam int DEF_NUM_SRC    = 3;
  localparam int DEF_DIV_W      = 3;
  localparam int DEF_SYNC_DELAY = 2;
  localparam int DEF_TIMEOUT    = 1023;

  localparam int SRC_21M = 0;
  localparam int SRC_14M = 1;
  localparam int SRC_25M = 2;

  function automatic int sel_width(input int num_src);
    return (num_src > 1) ? $clog2(num_src) : 1;
  endfunction

endpackage

// File: rtl/t9990_clock_gen_if.sv
// ---------------------------------------------------------------------------
// t9990_clock_gen_if
// Bundle between the clock-enable source side (master) and the dot-clock
// generator (slave).
//   SRC_EN[NUM_SRC]   master clock-enable pulses, one per source
//   SRC_SEL           selected source index
//   DIV[DIV_W]        dot divider ratio minus 1
//   RAM_REQ           memory access slot strobe
//   CLK_MASTER_EN     selected master enable (combinational)
//   MEM_REQ           RAM_REQ passed through
//   DCLK_EN           dot-clock enable pulse
//   TG_EN             timing generator run permission
//   DCLK_PHASE        current divider count
//   LOCKED            running after a genuine alignment
//   SYNC_FAIL         sticky sync timeout flag
//   DRIFT_ERR         phase drift pulse (only with T9990_CLOCK_GEN_DRIFT_CHECK_EN)
// ---------------------------------------------------------------------------
interface t9990_clock_gen_if
  import t9990_clock_pkg::*;
#(
  parameter int NUM_SRC = DEF_NUM_SRC,
  parameter int DIV_W   = DEF_DIV_W
);
  logic [NUM_SRC-1:0]              SRC_EN;
  logic [sel_width(NUM_SRC)-1:0]   SRC_SEL;
  logic [DIV_W-1:0]                DIV;
  logic                            RAM_REQ;
  logic                            CLK_MASTER_EN;
  logic                            MEM_REQ;
  logic                            DCLK_EN;
  logic                            TG_EN;
  logic [DIV_W-1:0]                DCLK_PHASE;
  logic                            LOCKED;
  logic                            SYNC_FAIL;
`ifdef T9990_CLOCK_GEN_DRIFT_CHECK_EN
  logic                            DRIFT_ERR;
`endif

  modport master (
    output SRC_EN, SRC_SEL, DIV, RAM_REQ,
    input  CLK_MASTER_EN, MEM_REQ, DCLK_EN, TG_EN, DCLK_PHASE, LOCKED, SYNC_FAIL
`ifdef T9990_CLOCK_GEN_DRIFT_CHECK_EN
    , input DRIFT_ERR
`endif
  );

  modport slave (
    input  SRC_EN, SRC_SEL, DIV, RAM_REQ,
    output CLK_MASTER_EN, MEM_REQ, DCLK_EN, TG_EN, DCLK_PHASE, LOCKED, SYNC_FAIL
`ifdef T9990_CLOCK_GEN_DRIFT_CHECK_EN
    , output DRIFT_ERR
`endif
  );

endinterface

// File: rtl/t9990_clock_sync_detect.sv
// ---------------------------------------------------------------------------
// t9990_clock_sync_detect
// Selects one master clock-enable stream and detects the memory slot phase.
//   CLK, RESET_n  clock, asynchronous active-low reset
//   src_en        master enable pulses, one per source
//   src_sel       source index; indices >= NUM_SRC select nothing
//   ram_req       memory access slot strobe
//   master_en     selected enable (combinational)
//   align         selected enable seen SYNC_DELAY cycles ago coincides with ram_req
// ---------------------------------------------------------------------------
module t9990_clock_sync_detect
  import t9990_clock_pkg::*;
#(
  parameter int NUM_SRC    = DEF_NUM_SRC,
  parameter int SYNC_DELAY = DEF_SYNC_DELAY
)(
  input  logic                          CLK,
  input  logic                          RESET_n,
  input  logic [NUM_SRC-1:0]            src_en,
  input  logic [sel_width(NUM_SRC)-1:0] src_sel,
  input  logic                          ram_req,
  output logic                          master_en,
  output logic                          align
);
  localparam int SEL_W = sel_width(NUM_SRC);

  logic                  master_en_s;
  logic [SYNC_DELAY-1:0] tap_r;

  // Source mux; an index past the last source matches no entry and reads idle.
  always_comb begin
    master_en_s = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      master_en_s = master_en_s | ((src_sel == SEL_W'(i)) & src_en[i]);
    end
  end

  // Delay the selected enable by the fixed lead it has over the slot strobe.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      tap_r <= {SYNC_DELAY{1'b0}};
    end else begin
      tap_r[0] <= master_en_s;
      for (int i = 1; i < SYNC_DELAY; i++) begin
        tap_r[i] <= tap_r[i-1];
      end
    end
  end

  assign master_en = master_en_s;
  assign align     = tap_r[SYNC_DELAY-1] & ram_req;

endmodule

// File: rtl/t9990_clock_gen.sv
// ---------------------------------------------------------------------------
// t9990_clock_gen
// Dot-clock enable generator: divides the selected master enable by DIV+1,
// phase-aligned to the memory access slot, and holds the timing generator
// off until alignment (or a sync timeout forces free-run).
//   CLK, RESET_n  clock, asynchronous active-low reset
//   bus (slave)   SRC_EN/SRC_SEL/DIV/RAM_REQ in; CLK_MASTER_EN, MEM_REQ,
//                 DCLK_EN, TG_EN, DCLK_PHASE, LOCKED, SYNC_FAIL out
// Optional: define T9990_CLOCK_GEN_DRIFT_CHECK_EN to drop lock when the slot
// strobe is seen at the wrong divider phase; DRIFT_ERR then pulses once.
// ---------------------------------------------------------------------------
module t9990_clock_gen
  import t9990_clock_pkg::*;
#(
  parameter int NUM_SRC    = DEF_NUM_SRC,
  parameter int DIV_W      = DEF_DIV_W,
  parameter int SYNC_DELAY = DEF_SYNC_DELAY,
  parameter int TIMEOUT    = DEF_TIMEOUT
)(
  input logic              CLK,
  input logic              RESET_n,
  t9990_clock_gen_if.slave bus
);
  localparam int SEL_W = sel_width(NUM_SRC);
  localparam int CFG_W = SEL_W + DIV_W;
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  logic             master_en_s;
  logic             align_s;
  logic             change_s;
  logic [CFG_W-1:0] cfg_r;
  state_t           state_r;
  logic [DIV_W-1:0] cnt_r;
  logic [TMO_W-1:0] tmo_r;
  logic             dclk_en_r;
  logic             tg_en_r;
  logic             locked_r;
  logic             sync_fail_r;
`ifdef T9990_CLOCK_GEN_DRIFT_CHECK_EN
  logic             drift_err_r;
`endif

  t9990_clock_sync_detect #(
    .NUM_SRC    (NUM_SRC),
    .SYNC_DELAY (SYNC_DELAY)
  ) u_sync_detect (
    .CLK       (CLK),
    .RESET_n   (RESET_n),
    .src_en    (bus.SRC_EN),
    .src_sel   (bus.SRC_SEL),
    .ram_req   (bus.RAM_REQ),
    .master_en (master_en_s),
    .align     (align_s)
  );

  // Last cycle's source/ratio; any difference from the live inputs is a change.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      cfg_r <= {CFG_W{1'b0}};
    end else begin
      cfg_r <= {bus.SRC_SEL, bus.DIV};
    end
  end

  assign change_s = (cfg_r != {bus.SRC_SEL, bus.DIV});

  // Sync/run state machine with the divider and all registered outputs.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_r     <= STATE_SYNCING;
      cnt_r       <= {DIV_W{1'b0}};
      tmo_r       <= {TMO_W{1'b0}};
      dclk_en_r   <= 1'b0;
      tg_en_r     <= 1'b0;
      locked_r    <= 1'b0;
      sync_fail_r <= 1'b0;
`ifdef T9990_CLOCK_GEN_DRIFT_CHECK_EN
      drift_err_r <= 1'b0;
`endif
    end else begin
`ifdef T9990_CLOCK_GEN_DRIFT_CHECK_EN
      drift_err_r <= 1'b0;
`endif
      if (change_s) begin
        // A config edit beats alignment and timeout: restart the hunt.
        state_r   <= STATE_SYNCING;
        cnt_r     <= bus.DIV;
        tmo_r     <= {TMO_W{1'b0}};
        dclk_en_r <= 1'b0;
        tg_en_r   <= 1'b0;
        locked_r  <= 1'b0;
      end else begin
        case (state_r)
          STATE_SYNCING: begin
            cnt_r     <= bus.DIV;
            dclk_en_r <= 1'b0;
            if (align_s) begin
              state_r     <= STATE_RUN;
              tmo_r       <= {TMO_W{1'b0}};
              tg_en_r     <= 1'b1;
              locked_r    <= 1'b1;
              sync_fail_r <= 1'b0;
            end else if (tmo_r == TMO_W'(TIMEOUT - 1)) begin
              // Give up on the slot phase and free-run; SYNC_FAIL stays set.
              state_r     <= STATE_RUN;
              tmo_r       <= {TMO_W{1'b0}};
              tg_en_r     <= 1'b1;
              locked_r    <= 1'b0;
              sync_fail_r <= 1'b1;
            end else begin
              tmo_r    <= tmo_r + TMO_W'(1);
              tg_en_r  <= 1'b0;
              locked_r <= 1'b0;
            end
          end
          STATE_RUN: begin
`ifdef T9990_CLOCK_GEN_DRIFT_CHECK_EN
            if (locked_r && align_s && (cnt_r != bus.DIV)) begin
              // Slot strobe arrived away from the reload phase: relock.
              state_r     <= STATE_SYNCING;
              cnt_r       <= bus.DIV;
              tmo_r       <= {TMO_W{1'b0}};
              dclk_en_r   <= 1'b0;
              tg_en_r     <= 1'b0;
              locked_r    <= 1'b0;
              drift_err_r <= 1'b1;
            end else
`endif
            if (master_en_s) begin
              if (cnt_r == {DIV_W{1'b0}}) begin
                dclk_en_r <= 1'b1;
                cnt_r     <= bus.DIV;
              end else begin
                dclk_en_r <= 1'b0;
                cnt_r     <= cnt_r - DIV_W'(1);
              end
            end else begin
              dclk_en_r <= 1'b0;
            end
          end
          default: begin
            state_r   <= STATE_SYNCING;
            dclk_en_r <= 1'b0;
            tg_en_r   <= 1'b0;
            locked_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.CLK_MASTER_EN = master_en_s;
  assign bus.MEM_REQ       = bus.RAM_REQ;
  assign bus.DCLK_EN       = dclk_en_r;
  assign bus.TG_EN         = tg_en_r;
  assign bus.DCLK_PHASE    = cnt_r;
  assign bus.LOCKED        = locked_r;
  assign bus.SYNC_FAIL     = sync_fail_r;
`ifdef T9990_CLOCK_GEN_DRIFT_CHECK_EN
  assign bus.DRIFT_ERR     = drift_err_r;
`endif

endmodule
